// File: rtl/imm_ext_pkg.sv
//------------------------------------------------------------------------------
// Module  : imm_ext_pkg
// Brief   : Shared op encodings and field constants for the immediate extender.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package imm_ext_pkg;

    localparam int EXT_OP_W = 3;

    typedef enum logic [EXT_OP_W-1:0] {
        EXT_ZERO        = 3'b000,
        EXT_SIGNED      = 3'b001,
        EXT_HIGHPOS     = 3'b010,
        EXT_SIGNED_SHL2 = 3'b011,
        EXT_SHAMT       = 3'b100
    } ext_op_e;

    // Shift-amount subfield position inside the raw immediate
    localparam int SHAMT_LSB = 6;
    localparam int SHAMT_W   = 5;

endpackage : imm_ext_pkg

`default_nettype wire

// File: rtl/ext_skid_buf.sv
//------------------------------------------------------------------------------
// Module  : ext_skid_buf
// Brief   : Two-entry in-order buffer; ready/valid derived from registered count.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ext_skid_buf #(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         in_ready,
    output logic         out_valid
);

    logic [W-1:0] r_mem [2];
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_count;

    logic w_push;
    logic w_pop;

    assign in_ready  = (r_count != 2'd2);
    assign out_valid = (r_count != 2'd0);
    assign w_push    = push && in_ready && !flush;
    assign w_pop     = pop && out_valid && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (flush) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) r_wr_ptr <= ~r_wr_ptr;
            if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: it is only visible while out_valid is high
    always_ff @(posedge clk) begin
        if (!rst && w_push) r_mem[r_wr_ptr] <= din;
    end

    assign dout = out_valid ? r_mem[r_rd_ptr] : '0;

endmodule : ext_skid_buf

`default_nettype wire

// File: rtl/imm_ext_pipe.sv
//------------------------------------------------------------------------------
// Module  : imm_ext_pipe
// Brief   : Immediate extender with 2-entry output buffer and illegal-op count.
//           Define IMM_EXT_SHAMT_EN to make op 100 (SHAMT) legal.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module imm_ext_pipe
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int ERR_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IN_W-1:0]     in_data,
    input  logic [EXT_OP_W-1:0] in_op,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OUT_W-1:0]    out_data,
    output logic                out_err,
    output logic [ERR_W-1:0]    err_cnt
);

    logic [OUT_W-1:0] w_sext;
    logic [OUT_W-1:0] w_ext;
    logic             w_illegal;
    logic             w_push;
    logic             w_pop;
    logic [OUT_W:0]   w_buf_dout;
    logic [ERR_W-1:0] r_err_cnt;

    assign w_sext = {{(OUT_W-IN_W){in_data[IN_W-1]}}, in_data};

    always_comb begin
        w_ext     = '0;
        w_illegal = 1'b0;
        case (in_op)
            EXT_ZERO:        w_ext = {{(OUT_W-IN_W){1'b0}}, in_data};
            EXT_SIGNED:      w_ext = w_sext;
            EXT_HIGHPOS:     w_ext = {in_data, {(OUT_W-IN_W){1'b0}}};
            EXT_SIGNED_SHL2: w_ext = {w_sext[OUT_W-3:0], 2'b00};
`ifdef IMM_EXT_SHAMT_EN
            EXT_SHAMT:       w_ext = {{(OUT_W-SHAMT_W){1'b0}}, in_data[SHAMT_LSB +: SHAMT_W]};
`endif
            default:         w_illegal = 1'b1;
        endcase
    end

    assign w_push = in_valid && in_ready && !flush;
    assign w_pop  = out_valid && out_ready;

    ext_skid_buf #(
        .W (OUT_W + 1)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (w_push),
        .pop       (w_pop),
        .din       ({w_illegal, w_ext}),
        .dout      (w_buf_dout),
        .in_ready  (in_ready),
        .out_valid (out_valid)
    );

    assign out_data = w_buf_dout[OUT_W-1:0];
    assign out_err  = w_buf_dout[OUT_W];

    // Counts accepted illegal entries only; flush never touches it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_cnt <= '0;
        end else if (w_push && w_illegal && (r_err_cnt != '1)) begin
            r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign err_cnt = r_err_cnt;

endmodule : imm_ext_pipe

`default_nettype wire

// File: tb/tb_imm_ext_pipe.sv
//------------------------------------------------------------------------------
// Module  : tb_imm_ext_pipe
// Brief   : Self-checking bench for imm_ext_pipe against a queue-based model.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_imm_ext_pipe;

    localparam int IN_W  = 16;
    localparam int OUT_W = 32;
    localparam int ERR_W = 8;
    localparam int ERR_MAX = (1 << ERR_W) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [IN_W-1:0]   in_data;
    logic [2:0]        in_op;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;
    logic              out_err;
    logic [ERR_W-1:0]  err_cnt;

    imm_ext_pipe #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .ERR_W (ERR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic        e;
    } ent_t;

    ent_t q[$];
    int   m_cnt;
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Extension computed arithmetically from the op definitions
    function automatic ent_t ref_ext(input logic [2:0] op, input logic [15:0] d);
        ent_t   r;
        longint s;
        longint v;
        s = (d >= 16'h8000) ? longint'(d) - 65536 : longint'(d);
        r.e = 1'b0;
        v   = 0;
        case (op)
            3'd0: v = longint'(d);
            3'd1: v = s;
            3'd2: v = longint'(d) * 65536;
            3'd3: v = s * 4;
`ifdef IMM_EXT_SHAMT_EN
            3'd4: v = (longint'(d) / 64) % 32;
`endif
            default: r.e = 1'b1;
        endcase
        r.d = v[31:0];
        return r;
    endfunction

    // One clock: drive, check against model before the edge, advance model
    task automatic cycle(input logic v, input logic [15:0] d, input logic [2:0] op,
                         input logic ordy, input logic fl, input string tag);
        ent_t e;
        bit   push;
        bit   pop;
        in_valid  = v;
        in_data   = d;
        in_op     = op;
        out_ready = ordy;
        flush     = fl;
        @(negedge clk);
        chk({tag, "/out_valid"}, 64'(out_valid), 64'(q.size() > 0));
        chk({tag, "/in_ready"}, 64'(in_ready), 64'(q.size() < 2));
        if (q.size() > 0) begin
            chk({tag, "/out_data"}, 64'(out_data), 64'(q[0].d));
            chk({tag, "/out_err"}, 64'(out_err), 64'(q[0].e));
        end
        chk({tag, "/err_cnt"}, 64'(err_cnt), 64'(m_cnt));
        push = v && (q.size() < 2) && !fl;
        pop  = (q.size() > 0) && ordy;
        if (fl) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (push) begin
                e = ref_ext(op, d);
                q.push_back(e);
                if (e.e && m_cnt < ERR_MAX) m_cnt++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        m_cnt = 0;
        chk("rst/out_valid", 64'(out_valid), 64'd0);
        chk("rst/in_ready", 64'(in_ready), 64'd1);
        chk("rst/out_data", 64'(out_data), 64'd0);
        chk("rst/out_err", 64'(out_err), 64'd0);
        chk("rst/err_cnt", 64'(err_cnt), 64'd0);
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_op = '0; out_ready = 1'b0;
        q.delete();
        m_cnt = 0;
        @(posedge clk);
        #1;
        do_reset();

        // Sign extension, one-cycle latency
        cycle(1'b1, 16'h8001, 3'd1, 1'b1, 1'b0, "signed");
        chk("signed/latency_valid", 64'(out_valid), 64'd1);
        chk("signed/value", 64'(out_data), 64'hFFFF8001);
        chk("signed/err", 64'(out_err), 64'd0);
        cycle(1'b0, 16'h0, 3'd0, 1'b1, 1'b0, "drain0");

        // Fill with consumer stalled, hold, then release
        cycle(1'b1, 16'h1234, 3'd2, 1'b0, 1'b0, "hipos");
        cycle(1'b1, 16'hFFFF, 3'd3, 1'b0, 1'b0, "shl2");
        chk("full/in_ready", 64'(in_ready), 64'd0);
        chk("full/head", 64'(out_data), 64'h12340000);
        cycle(1'b1, 16'h5555, 3'd0, 1'b0, 1'b0, "hold");
        chk("hold/head", 64'(out_data), 64'h12340000);
        cycle(1'b0, 16'h0, 3'd0, 1'b1, 1'b0, "rel1");
        chk("rel/in_ready", 64'(in_ready), 64'd1);
        chk("rel/second", 64'(out_data), 64'hFFFFFFFC);
        cycle(1'b0, 16'h0, 3'd0, 1'b1, 1'b0, "rel2");

        // Streaming at count 1: no bubbles
        cycle(1'b1, 16'h0001, 3'd0, 1'b0, 1'b0, "prime");
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 16'(16'h0100 + i), 3'd0, 1'b1, 1'b0, "stream");
            chk("stream/valid", 64'(out_valid), 64'd1);
            chk("stream/order", 64'(out_data), 64'(16'h0100 + i));
        end
        cycle(1'b0, 16'h0, 3'd0, 1'b1, 1'b0, "sdrain");

        // Flush while full, with a competing push
        cycle(1'b1, 16'h0AAA, 3'd7, 1'b0, 1'b0, "fill_a");
        cycle(1'b1, 16'h0BBB, 3'd0, 1'b0, 1'b0, "fill_b");
        cycle(1'b1, 16'h0CCC, 3'd0, 1'b1, 1'b1, "flush");
        chk("flush/out_valid", 64'(out_valid), 64'd0);
        chk("flush/in_ready", 64'(in_ready), 64'd1);
        chk("flush/err_cnt", 64'(err_cnt), 64'd1);
        cycle(1'b0, 16'h0, 3'd0, 1'b1, 1'b0, "postflush");

        // Illegal ops count
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 16'hBEEF, 3'd7, 1'b1, 1'b0, "illegal");
            chk("illegal/data", 64'(out_data), 64'd0);
            chk("illegal/err", 64'(out_err), 64'd1);
        end
        cycle(1'b0, 16'h0, 3'd0, 1'b1, 1'b0, "illdrain");
        chk("illegal/cnt3", 64'(err_cnt), 64'd3);

        // Shift-amount op
        cycle(1'b1, 16'h07C0, 3'd4, 1'b1, 1'b0, "shamt");
`ifdef IMM_EXT_SHAMT_EN
        chk("shamt/data", 64'(out_data), 64'h1F);
        chk("shamt/err", 64'(out_err), 64'd0);
`else
        chk("shamt/data", 64'(out_data), 64'd0);
        chk("shamt/err", 64'(out_err), 64'd1);
`endif
        cycle(1'b0, 16'h0, 3'd0, 1'b1, 1'b0, "shdrain");

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle(1'b1 && ($urandom_range(0, 3) != 0), 16'($urandom), 3'($urandom_range(0, 7)),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0), "rand");
        end

        // Reset mid-transfer drops everything
        cycle(1'b1, 16'h1111, 3'd0, 1'b0, 1'b0, "pre_a");
        cycle(1'b1, 16'h2222, 3'd0, 1'b0, 1'b0, "pre_b");
        in_valid = 1'b1; out_ready = 1'b1; flush = 1'b1;
        do_reset();
        cycle(1'b0, 16'h0, 3'd0, 1'b1, 1'b0, "postrst");

        // Saturation of the illegal counter
        for (int i = 0; i < ERR_MAX + 5; i++) begin
            cycle(1'b1, 16'(i), 3'd6, 1'b1, 1'b0, "sat");
        end
        chk("sat/max", 64'(err_cnt), 64'(ERR_MAX));
        cycle(1'b1, 16'h0, 3'd5, 1'b1, 1'b0, "sat_hold");
        chk("sat/hold", 64'(err_cnt), 64'(ERR_MAX));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_imm_ext_pipe

`default_nettype wire
